// File: rtl/log_sum.sv
// log_sum: accumulates a valid/last frame and emits floor(ln(sum)) via a 4-step pipelined search.
// Optional LOG_SUM_OVF_EN adds output_overflow, flagging frames that saturated the accumulator.
module log_sum #(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] input_tdata,
    input  logic                  input_tvalid,
    input  logic                  input_tlast,
    output logic [DATA_WIDTH-1:0] output_tdata,
    output logic                  output_tvalid,
    output logic                  output_tlast
`ifdef LOG_SUM_OVF_EN
    ,
    output logic                  output_overflow
`endif
);

    typedef logic [ACC_WIDTH-1:0] acc_t;
    typedef logic [ACC_WIDTH:0]   ext_t;

    typedef struct packed {
        logic       v;
        logic       zero;
        logic [3:0] k;
        acc_t       sum;
    } stage_t;

    // T[k] = ceil(e^k)
    function automatic acc_t thresh(input logic [3:0] idx);
        case (idx)
            4'd0:    return acc_t'(32'd1);
            4'd1:    return acc_t'(32'd3);
            4'd2:    return acc_t'(32'd8);
            4'd3:    return acc_t'(32'd21);
            4'd4:    return acc_t'(32'd55);
            4'd5:    return acc_t'(32'd149);
            4'd6:    return acc_t'(32'd404);
            4'd7:    return acc_t'(32'd1097);
            4'd8:    return acc_t'(32'd2981);
            4'd9:    return acc_t'(32'd8104);
            4'd10:   return acc_t'(32'd22027);
            4'd11:   return acc_t'(32'd59875);
            4'd12:   return acc_t'(32'd162755);
            4'd13:   return acc_t'(32'd442414);
            4'd14:   return acc_t'(32'd1202605);
            default: return acc_t'(32'd3269018);
        endcase
    endfunction

    // Tentatively set bit b of the prefix and keep it if the sum reaches that threshold.
    function automatic stage_t step(input stage_t s, input logic [1:0] b);
        stage_t     r;
        logic [3:0] probe;
        r        = s;
        probe    = s.k;
        probe[b] = 1'b1;
        if (s.sum >= thresh(probe)) begin
            r.k = probe;
        end
        return r;
    endfunction

    acc_t   acc;
    ext_t   sum_ext;
    logic   carry;
    acc_t   next_sum;
    stage_t s0, s1, s2, s3, s4n;

    always_comb begin
        sum_ext  = ext_t'(acc) + ext_t'(input_tdata);
        carry    = sum_ext[ACC_WIDTH];
        next_sum = carry ? '1 : sum_ext[ACC_WIDTH-1:0];
        s4n      = step(s3, 2'd0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc           <= '0;
            s0.v          <= 1'b0;
            s1.v          <= 1'b0;
            s2.v          <= 1'b0;
            s3.v          <= 1'b0;
            output_tvalid <= 1'b0;
            output_tdata  <= '0;
        end else begin
            if (input_tvalid) begin
                acc <= input_tlast ? '0 : next_sum;
            end
            s0.v    <= input_tvalid & input_tlast;
            s0.sum  <= next_sum;
            s0.zero <= (next_sum == '0);
            s0.k    <= '0;
            s1      <= step(s0, 2'd3);
            s2      <= step(s1, 2'd2);
            s3      <= step(s2, 2'd1);
            output_tvalid <= s3.v;
            if (s3.v) begin
                output_tdata <= s4n.zero ? DATA_WIDTH'(16'h8000) : DATA_WIDTH'(s4n.k);
            end
        end
    end

    assign output_tlast = output_tvalid;

`ifdef LOG_SUM_OVF_EN
    logic       acc_sat;
    logic [3:0] sat_pipe;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_sat         <= 1'b0;
            sat_pipe        <= '0;
            output_overflow <= 1'b0;
        end else begin
            if (input_tvalid) begin
                acc_sat <= input_tlast ? 1'b0 : (acc_sat | carry);
            end
            sat_pipe        <= {sat_pipe[2:0], acc_sat | carry};
            output_overflow <= s3.v & sat_pipe[3];
        end
    end
`endif

endmodule

// File: doc/log_sum.md
Name: log_sum

Overview:
- Streaming inverse of the exp lookup. Consumes a frame of non-negative exp-domain integers on a valid/last stream and accumulates them.
- At the end of each frame, emits one beat: floor(ln(sum)), found by a pipelined 4-step binary search over a 16-entry threshold table.
- Sits after exp in the digital-compute datapath and closes the log-sum-exp / log-softmax path.
- Fully pipelined: back-to-back frames, including single-beat frames every cycle, need no stall and no tready.

Parameters:
- DATA_WIDTH, 16: input/output beat width; must be >= 16.
- ACC_WIDTH, 32: accumulator width; must be >= 22 so the largest threshold, 3269018, is representable.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset; one clock; reset is synchronous and active-low
- input_tdata  input  DATA_WIDTH  unsigned exp-domain value
- input_tvalid  input  1  beat valid; no backpressure exists
- input_tlast  input  1  last beat of frame; qualified by input_tvalid
- output_tdata  output  DATA_WIDTH  result k (0..15, zero-extended), or 16'h8000 for a zero sum (-inf code)
- output_tvalid  output  1  one-cycle pulse per completed frame
- output_tlast  output  1  equals output_tvalid; every result beat is a frame of one

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - accumulator, saturation flag and all pipeline stage valids clear to 0;
  - output_tdata, output_tvalid and output_tlast are 0 on the following cycle;
  - in-flight frames and partial sums are discarded with no output.
- Accumulate:
  - next_sum = acc + zero_extend(input_tdata), saturating at 2^ACC_WIDTH-1;
  - the saturation flag is sticky for the frame.
  - Sampled beat with input_tvalid=1 and tlast=0: acc <= next_sum.
  - Sampled beat with input_tvalid=1 and tlast=1: next_sum and the flag load capture stage S0 (valid=1); acc and flag clear to 0 on the same edge, so the next frame starts clean on the very next cycle.
  - input_tvalid=0: acc holds; input_tlast is ignored.
- Threshold table, T[k] = ceil(e^k), k=0..15:
  - 1, 3, 8, 21, 55, 149, 404, 1097, 2981, 8104, 22027, 59875, 162755, 442414, 1202605, 3269018.
- Result k: the largest k with sum >= T[k].
  - Any sum >= 3269018, including a saturated sum, gives 15.
  - sum = 0 gives code 16'h8000.
- Pipeline, stages S1..S4, each registered:
  - S1 decides result bit 3 by comparing the sum with T[8];
  - S2 decides bit 2 with T[prefix|4];
  - S3 decides bit 1;
  - S4 decides bit 0.
  - Each stage carries its valid, the sum and the zero flag forward.
  - The S4 register drives the outputs directly.
- Latency: the tlast beat sampled at edge N gives output_tvalid=1 in the cycle after edge N+4.
  - Throughput is one result per cycle.
  - output_tvalid is never high for two consecutive cycles for the same frame.
- When output_tvalid=0, output_tdata holds its last value; output_tlast=0.
- Frame of length 1 (tvalid and tlast on the first beat) is legal. Its sum is that beat alone, ignoring any accumulated value from a frame that was never terminated? No: any pending partial accumulation is included, because frames are delimited only by tlast.

Optional Feature:
- Macro LOG_SUM_OVF_EN.
- Defined:
  - adds output port output_overflow (1 bit, reset 0);
  - it is registered alongside output_tdata and is 1 on a result beat whose frame saturated the accumulator, else 0.
- Undefined:
  - the port is absent and saturation is silent;
  - result behaviour is identical in both builds.

Test Plan:
- Frame {1,3,7}, tlast on 7 -> one beat output_tdata=2 (8<=11<21), tvalid exactly 4 cycles after the tlast edge, tlast=1.
- Frame {20,55,148} (sum 223) followed immediately by frame {2981,5123} (sum 8104) -> outputs 5 then 9 on two cycles, exactly one cycle apart.
- Single-beat frames 0, 1, 3, 8 on consecutive cycles -> outputs 16'h8000, 0, 1, 2 on consecutive cycles.
- ACC_WIDTH=22, 65 beats of 16'hFFFF -> output 15; with LOG_SUM_OVF_EN, output_overflow=1. A following frame {2} -> output 0 with output_overflow=0.
- Frame {100,100} with tvalid gaps of 3 idle cycles between beats, with input_tlast toggling while tvalid=0 -> single output 5 (sum 200).
- rst_n low for one cycle after beats {500,500} (no tlast), then frame {3} -> no output for the aborted frame; output 1 for {3}. rst_n low while a result is in S2 -> that result never appears; all outputs 0 the next cycle.
